// File: rtl/asphalt_key_debounce_pkg.sv
// Shared types for the key debouncer: the per-cycle debounce action and its decode.
package asphalt_key_debounce_pkg;

  typedef enum logic [1:0] {
    DB_IDLE   = 2'd0,
    DB_COUNT  = 2'd1,
    DB_COMMIT = 2'd2
  } db_action_e;

  // Agreement with the current level clears the count; a full-length disagreement commits.
  function automatic db_action_e db_decide(input logic sample, input logic level,
                                           input logic at_max);
    db_action_e act;
    if (sample == level) act = DB_IDLE;
    else if (at_max)     act = DB_COMMIT;
    else                 act = DB_COUNT;
    return act;
  endfunction

endpackage

// File: rtl/asphalt_key_debounce_ch.sv
// One key channel: 2-flop synchroniser, stability counter, debounced level and edge pulses.
module asphalt_key_debounce_ch
  import asphalt_key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pressed,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("asphalt_key_debounce_ch: DEBOUNCE_CYCLES must be >= 2");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync_p0;
  logic             r_sync_p1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  db_action_e       w_action;

  always_comb begin
    w_action = db_decide(r_sync_p1, r_level, (r_cnt == CNT_MAX));
  end

  // Stage boundary: synchroniser feeds the counter; pulses register alongside the level
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync_p0 <= i_pressed;
      r_sync_p1 <= r_sync_p0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (w_action)
        DB_COUNT:  r_cnt <= r_cnt + CNT_W'(1);
        DB_COMMIT: begin
          r_cnt     <= '0;
          r_level   <= r_sync_p1;
          r_press   <= r_sync_p1;
          r_release <= ~r_sync_p1;
        end
        default:   r_cnt <= '0;
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/asphalt_key_debounce.sv
// Push-button conditioning for the key PIO: polarity normalisation plus one debounce channel per key.
module asphalt_key_debounce
  import asphalt_key_debounce_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  logic [NUM_KEYS-1:0] w_pressed;

  assign w_pressed = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    asphalt_key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_pressed(w_pressed[g]),
      .o_level  (key_level[g]),
      .o_press  (key_press[g]),
      .o_release(key_release[g])
    );
  end

endmodule

// File: tb/tb_asphalt_key_debounce.sv
// Scoreboard bench for asphalt_key_debounce with DEBOUNCE_CYCLES=8, active-low keys, two channels.
module tb_asphalt_key_debounce;

  localparam int NK  = 2;
  localparam int DB  = 8;
  localparam int LAT = DB + 2;

  typedef struct {
    int         cyc;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [1:0] exp_level;

  asphalt_key_debounce #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DB),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the queue, on the predicted cycle
  always @(negedge clk) begin
    ev_t e;
    if (key_press !== 2'b00 || key_release !== 2'b00) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: press=%b release=%b level=%b at cycle %0d, none expected",
                 key_press, key_release, key_level, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("level", {30'd0, key_level}, {30'd0, e.level});
        check("press", {30'd0, key_press}, {30'd0, e.press});
        check("release", {30'd0, key_release}, {30'd0, e.rel});
      end
    end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missed_pulse: no pulse by cycle %0d, expected press=%b release=%b at cycle %0d",
               cyc, e.press, e.rel, e.cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic [1:0] newl);
    ev_t e;
    e.cyc   = cyc + LAT;
    e.level = newl;
    e.press = newl & ~exp_level;
    e.rel   = exp_level & ~newl;
    exp_q.push_back(e);
    exp_level = newl;
  endtask

  // Clean step to a new raw value; raw low means pressed
  task automatic step(input logic [1:0] raw);
    key_raw = raw;
    push_ev(~raw);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      tick(1);
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d events still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    tick(2);
  endtask

  initial begin
    reset_n   = 1'b0;
    key_raw   = 2'b00;
    exp_level = 2'b00;

    // 1: both keys held through reset, then qualify together
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("reset_outputs", {26'd0, key_level, key_press, key_release}, 32'd0);
    end
    reset_n = 1'b1;
    push_ev(2'b11);
    tick(LAT - 1);
    check("level_before_latency", {30'd0, key_level}, 32'd0);
    drain();

    // 2: release key 0, then clean press
    step(2'b01);
    drain();
    step(2'b00);
    drain();
    check("level_after_press", {30'd0, key_level}, 32'd3);

    // 3: short low glitch on a released key 0 is rejected
    step(2'b01);
    drain();
    key_raw = 2'b00;
    tick(5);
    key_raw = 2'b01;
    tick(15);
    check("glitch_level", {30'd0, key_level}, 32'd2);

    // 4: bounce, then settle low
    key_raw = 2'b00;
    tick(3);
    key_raw = 2'b01;
    tick(2);
    step(2'b00);
    drain();

    // 5: both keys released on the same cycle
    step(2'b11);
    drain();
    check("both_released", {30'd0, key_level}, 32'd0);

    // 6: reset mid-count on key 1 while key 0 is pressed
    step(2'b10);
    drain();
    key_raw = 2'b00;
    tick(7);
    reset_n = 1'b0;
    tick(1);
    check("midcount_reset", {26'd0, key_level, key_press, key_release}, 32'd0);
    reset_n   = 1'b1;
    exp_level = 2'b00;
    push_ev(2'b11);
    drain();
    check("requalified", {30'd0, key_level}, 32'd3);

    tick(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
